// File: rtl/cr16_controller.sv
// CR16 instruction sequencer: FETCH -> DECODE -> EXECUTE (-> MEM -> WB for LOAD), HALT absorbing.
// Optional: define CR16_CONTROLLER_ILLEGAL_TRAP_EN to halt on undefined op/ext encodings (default: execute as NOP).
module cr16_controller #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        I_CLK,
    input  logic        I_RESET,
    input  logic        I_ENABLE,
    input  logic [15:0] I_INSTRUCTION,
    input  logic [4:0]  I_STATUS_FLAGS,
    output logic [15:0] O_PC,
    output logic        O_MEM_READ,
    output logic        O_MEM_WRITE,
    output logic [15:0] O_REG_WRITE_ENABLE,
    output logic [3:0]  O_REG_A_SELECT,
    output logic [3:0]  O_REG_B_SELECT,
    output logic [15:0] O_IMMEDIATE,
    output logic        O_IMMEDIATE_SELECT,
    output logic [3:0]  O_OPCODE,
    output logic        O_REG_DATA_SELECT,
    output logic        O_HALTED
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT} state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0100, ALU_AND = 4'b0110,
                           ALU_OR  = 4'b0111, ALU_XOR = 4'b1000, ALU_PASS_B = 4'b1010;
    // Function codes shared by register-form ext and immediate-form op.
    localparam logic [3:0] F_ADD = 4'b0101, F_SUB = 4'b1001, F_AND = 4'b0001, F_OR = 4'b0010,
                           F_XOR = 4'b0011, F_CMP = 4'b1011, F_MOV = 4'b1101;
    localparam logic [3:0] OP_REG = 4'b0000, OP_MEM = 4'b0100, OP_BCOND = 4'b1100, OP_LUI = 4'b1111;
    localparam logic [3:0] X_LOAD = 4'b0000, X_STOR = 4'b0100;

`ifdef CR16_CONTROLLER_ILLEGAL_TRAP_EN
    localparam bit TRAP_ILLEGAL = 1'b1;
`else
    localparam bit TRAP_ILLEGAL = 1'b0;
`endif

    typedef struct packed {
        logic        write;
        logic [3:0]  a_sel;
        logic [3:0]  b_sel;
        logic [15:0] imm;
        logic        imm_sel;
        logic [3:0]  alu_op;
        logic        mem_read;
        logic        mem_write;
        logic        load;
        logic        branch;
        logic        set_flags;
        logic        halt;
        logic        illegal;
    } ctrl_t;

    state_t      state, state_next;
    logic [15:0] pc, pc_next, ir, imm_sext;
    logic [4:0]  flags, flags_next, alu_m;
    logic [3:0]  op, rdest, ext, rsrc;
    logic [7:0]  imm8;
    logic        taken, unused_flags;
    ctrl_t       dec;

    assign op       = ir[15:12];
    assign rdest    = ir[11:8];
    assign ext      = ir[7:4];
    assign rsrc     = ir[3:0];
    assign imm8     = ir[7:0];
    assign imm_sext = {{8{imm8[7]}}, imm8};
    assign O_PC     = pc;
    assign unused_flags = ^flags[2:1];

    // Returns {valid, alu_op} for a function code.
    function automatic logic [4:0] alu_map(input logic [3:0] code);
        case (code)
            F_ADD:   return {1'b1, ALU_ADD};
            F_SUB:   return {1'b1, ALU_SUB};
            F_AND:   return {1'b1, ALU_AND};
            F_OR:    return {1'b1, ALU_OR};
            F_XOR:   return {1'b1, ALU_XOR};
            F_CMP:   return {1'b1, ALU_SUB};
            F_MOV:   return {1'b1, ALU_PASS_B};
            default: return {1'b0, ALU_ADD};
        endcase
    endfunction

    assign alu_m = alu_map((op == OP_REG) ? ext : op);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
        dec = '0;
        if (ir == 16'h0000) begin
            dec.halt = 1'b1;
        end else begin
            case (op)
                OP_REG: begin
                    dec.illegal   = ~alu_m[4];
                    dec.a_sel     = rdest;
                    dec.b_sel     = rsrc;
                    dec.alu_op    = alu_m[3:0];
                    dec.write     = alu_m[4] && (ext != F_CMP);
                    dec.set_flags = (ext == F_ADD) || (ext == F_SUB) || (ext == F_CMP);
                end
                F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_CMP, F_MOV: begin
                    dec.a_sel     = rdest;
                    dec.imm_sel   = 1'b1;
                    dec.alu_op    = alu_m[3:0];
                    dec.imm       = (op == F_AND || op == F_OR || op == F_XOR) ? {8'h00, imm8} : imm_sext;
                    dec.write     = (op != F_CMP);
                    dec.set_flags = (op == F_ADD) || (op == F_SUB) || (op == F_CMP);
                end
                OP_LUI: begin
                    dec.imm_sel = 1'b1;
                    dec.imm     = {imm8, 8'h00};
                    dec.alu_op  = ALU_PASS_B;
                    dec.write   = 1'b1;
                end
                OP_MEM: begin
                    dec.b_sel = rsrc;
                    if (ext == X_LOAD) begin
                        dec.mem_read = 1'b1;
                        dec.load     = 1'b1;
                    end else if (ext == X_STOR) begin
                        dec.a_sel     = rdest;
                        dec.mem_write = 1'b1;
                    end else begin
                        dec.illegal = 1'b1;
                    end
                end
                OP_BCOND: dec.branch = 1'b1;
                default:  dec.illegal = 1'b1;
            endcase
        end
    end

    // Branch conditions read the latched flags: [0]C [3]Z [4]N.
    always_comb begin
        case (rdest)
            4'b0000: taken = flags[3];
            4'b0001: taken = ~flags[3];
            4'b0010: taken = flags[0];
            4'b0011: taken = ~flags[0];
            4'b0110: taken = flags[4];
            4'b0111: taken = ~flags[4];
            4'b1110: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        flags_next = flags;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: state_next = S_EXECUTE;
            S_EXECUTE: begin
                if (dec.halt || (dec.illegal && TRAP_ILLEGAL)) begin
                    state_next = S_HALT;
                end else if (dec.load) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_FETCH;
                    pc_next    = (dec.branch && taken) ? pc + imm_sext : pc + 16'd1;
                    if (dec.set_flags) flags_next = I_STATUS_FLAGS;
                end
            end
            S_MEM: state_next = S_WB;
            S_WB: begin
                state_next = S_FETCH;
                pc_next    = pc + 16'd1;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge I_CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (I_RESET) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            flags <= '0;
            ir    <= '0;
        end else if (I_ENABLE) begin
            state <= state_next;
            pc    <= pc_next;
            flags <= flags_next;
            if (state == S_DECODE) ir <= I_INSTRUCTION;
        end
    end

    always_comb begin
        O_MEM_READ         = 1'b0;
        O_MEM_WRITE        = 1'b0;
        O_REG_WRITE_ENABLE = '0;
        O_REG_A_SELECT     = '0;
        O_REG_B_SELECT     = '0;
        O_IMMEDIATE        = '0;
        O_IMMEDIATE_SELECT = 1'b0;
        O_OPCODE           = '0;
        O_REG_DATA_SELECT  = 1'b0;
        O_HALTED           = 1'b0;
        if (!I_RESET) begin
            case (state)
                S_FETCH: O_MEM_READ = 1'b1;
                S_EXECUTE: begin
                    O_REG_A_SELECT     = dec.a_sel;
                    O_REG_B_SELECT     = dec.b_sel;
                    O_IMMEDIATE        = dec.imm;
                    O_IMMEDIATE_SELECT = dec.imm_sel;
                    O_OPCODE           = dec.alu_op;
                    O_MEM_READ         = dec.mem_read;
                    O_MEM_WRITE        = dec.mem_write;
                    O_REG_WRITE_ENABLE = dec.write ? (16'h0001 << rdest) : 16'h0000;
                end
                S_WB: begin
                    O_REG_B_SELECT     = rsrc;
                    O_REG_DATA_SELECT  = 1'b1;
                    O_REG_WRITE_ENABLE = 16'h0001 << rdest;
                end
                S_HALT:  O_HALTED = 1'b1;
                default: ;
            endcase
            // A stalled controller must not strobe memory or write registers.
            if (!I_ENABLE) begin
                O_MEM_READ         = 1'b0;
                O_MEM_WRITE        = 1'b0;
                O_REG_WRITE_ENABLE = '0;
            end
        end
    end
endmodule

// File: tb/tb_cr16_controller.sv
// Self-checking bench for cr16_controller: directed test-plan scenarios plus a random
// instruction stream (with random stalls) checked against an instruction-level model.
module tb_cr16_controller;
    logic        clk = 1'b0;
    logic        rst, en;
    logic [15:0] instr;
    logic [4:0]  sflags;
    logic [15:0] pc, we, imm;
    logic        mem_read, mem_write, imm_sel, rds, halted;
    logic [3:0]  a_sel, b_sel, opc;

    always #5 clk = ~clk;

    cr16_controller dut (
        .I_CLK(clk), .I_RESET(rst), .I_ENABLE(en), .I_INSTRUCTION(instr), .I_STATUS_FLAGS(sflags),
        .O_PC(pc), .O_MEM_READ(mem_read), .O_MEM_WRITE(mem_write), .O_REG_WRITE_ENABLE(we),
        .O_REG_A_SELECT(a_sel), .O_REG_B_SELECT(b_sel), .O_IMMEDIATE(imm),
        .O_IMMEDIATE_SELECT(imm_sel), .O_OPCODE(opc), .O_REG_DATA_SELECT(rds), .O_HALTED(halted)
    );

`ifdef CR16_CONTROLLER_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    int tests = 0, failed = 0;
    logic [15:0] m_pc;
    logic [4:0]  m_flags;

    // Expected architectural effect of one instruction; c* bits mark which datapath fields matter.
    typedef struct packed {
        logic [15:0] we, wb_we, imm, npc;
        logic [3:0]  a, b, opc;
        logic        ca, cb, co, ci, cs, isel, rd, wr, load, setf, halt;
    } exp_t;

    // ALU mnemonic table: {known, alu opcode} for a function code.
    function automatic logic [4:0] alu_of(input logic [3:0] code);
        case (code)
            4'b0101: return 5'b1_0000;  // ADD
            4'b1001: return 5'b1_0100;  // SUB
            4'b0001: return 5'b1_0110;  // AND
            4'b0010: return 5'b1_0111;  // OR
            4'b0011: return 5'b1_1000;  // XOR
            4'b1011: return 5'b1_0100;  // CMP
            4'b1101: return 5'b1_1010;  // MOV
            default: return 5'b0_0000;
        endcase
    endfunction

    function automatic exp_t model(input logic [15:0] ins, input logic [15:0] cur_pc, input logic [4:0] fl);
        exp_t e;
        logic [3:0] op, rd, ex, rs, code;
        logic [7:0] i8;
        logic [15:0] sx;
        logic [4:0] k;
        logic t;
        op = ins[15:12]; rd = ins[11:8]; ex = ins[7:4]; rs = ins[3:0]; i8 = ins[7:0];
        sx = {{8{i8[7]}}, i8};
        e = '0;
        e.npc = cur_pc + 16'd1;
        if (ins == 16'h0000) begin
            e.halt = 1'b1; e.npc = cur_pc;
        end else if (op == 4'hF) begin
            e.co = 1; e.opc = 4'b1010; e.cs = 1; e.isel = 1; e.ci = 1; e.imm = {i8, 8'h00};
            e.we = 16'h0001 << rd;
        end else if (op == 4'h4 && ex == 4'h0) begin
            e.cb = 1; e.b = rs; e.rd = 1; e.cs = 1; e.load = 1; e.wb_we = 16'h0001 << rd;
        end else if (op == 4'h4 && ex == 4'h4) begin
            e.ca = 1; e.a = rd; e.cb = 1; e.b = rs; e.wr = 1; e.cs = 1;
        end else if (op == 4'hC) begin
            case (rd)
                4'h0: t = fl[3];  4'h1: t = !fl[3];
                4'h2: t = fl[0];  4'h3: t = !fl[0];
                4'h6: t = fl[4];  4'h7: t = !fl[4];
                4'hE: t = 1'b1;
                default: t = 1'b0;
            endcase
            if (t) e.npc = cur_pc + sx;
        end else begin
            code = (op == 4'h0) ? ex : op;
            k = alu_of(code);
            if (!k[4]) begin
                if (TRAP) begin e.halt = 1'b1; e.npc = cur_pc; end
            end else begin
                e.ca = 1; e.a = rd; e.co = 1; e.opc = k[3:0]; e.cs = 1; e.isel = (op != 4'h0);
                if (op == 4'h0) begin e.cb = 1; e.b = rs; end
                else begin
                    e.ci = 1;
                    e.imm = (code == 4'b0001 || code == 4'b0010 || code == 4'b0011) ? {8'h00, i8} : sx;
                end
                e.we = (code == 4'b1011) ? 16'h0000 : (16'h0001 << rd);
                e.setf = (code == 4'b0101 || code == 4'b1001 || code == 4'b1011);
            end
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b1;
        step(); step();
        rst = 1'b0; #1;
        m_pc = 16'h0000; m_flags = 5'b0;
    endtask

    // Advance one clock, optionally preceded by a random stall with I_ENABLE low.
    task automatic pause(input bit stall);
        if (stall && $urandom_range(0, 3) == 0) begin
            en = 1'b0;
            repeat ($urandom_range(1, 3)) begin
                step();
                tests++;
                if (mem_read !== 1'b0 || mem_write !== 1'b0 || we !== 16'h0 || pc !== m_pc) begin
                    failed++;
                    $display("FAIL stall: rd=%b wr=%b we=%h pc=%h, expected 0 0 0000 pc=%h", mem_read, mem_write, we, pc, m_pc);
                end
            end
            en = 1'b1;
        end
        step();
    endtask

    // Run one instruction from FETCH to the next FETCH (or into HALT), checking every cycle.
    task automatic exec(input logic [15:0] ins, input logic [4:0] fl, input bit stall);
        exp_t e;
        e = model(ins, m_pc, m_flags);
        tests++;
        if (mem_read !== 1'b1 || pc !== m_pc || we !== 16'h0 || halted !== 1'b0) begin
            failed++;
            $display("FAIL fetch %h: rd=%b pc=%h we=%h halted=%b, expected 1 %h 0000 0", ins, mem_read, pc, we, halted, m_pc);
        end
        pause(stall);
        instr = ins;
        tests++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || we !== 16'h0) begin
            failed++;
            $display("FAIL decode %h: rd=%b wr=%b we=%h, expected 0 0 0000", ins, mem_read, mem_write, we);
        end
        pause(stall);
        instr = 16'($urandom); sflags = fl;
        tests++;
        if (we !== e.we || mem_read !== e.rd || mem_write !== e.wr || rds !== 1'b0 || halted !== 1'b0) begin
            failed++;
            $display("FAIL exec_ctrl %h: we=%h rd=%b wr=%b rds=%b halted=%b, expected we=%h rd=%b wr=%b 0 0",
                     ins, we, mem_read, mem_write, rds, halted, e.we, e.rd, e.wr);
        end
        tests++;
        if ((e.ca && a_sel !== e.a) || (e.cb && b_sel !== e.b) || (e.co && opc !== e.opc) ||
            (e.cs && imm_sel !== e.isel) || (e.ci && imm !== e.imm)) begin
            failed++;
            $display("FAIL exec_dp %h: a=%h b=%h op=%b isel=%b imm=%h, expected a=%h b=%h op=%b isel=%b imm=%h",
                     ins, a_sel, b_sel, opc, imm_sel, imm, e.a, e.b, e.opc, e.isel, e.imm);
        end
        pause(stall);
        if (e.halt) begin
            tests++;
            if (halted !== 1'b1 || pc !== m_pc || mem_read !== 1'b0) begin
                failed++;
                $display("FAIL halt_entry %h: halted=%b pc=%h rd=%b, expected 1 %h 0", ins, halted, pc, mem_read, m_pc);
            end
            return;
        end
        if (e.load) begin
            tests++;
            if (we !== 16'h0 || rds !== 1'b0 || mem_read !== 1'b0 || pc !== m_pc) begin
                failed++;
                $display("FAIL load_mem %h: we=%h rds=%b rd=%b pc=%h, expected 0000 0 0 %h", ins, we, rds, mem_read, pc, m_pc);
            end
            pause(stall);
            tests++;
            if (we !== e.wb_we || rds !== 1'b1 || mem_read !== 1'b0) begin
                failed++;
                $display("FAIL load_wb %h: we=%h rds=%b rd=%b, expected %h 1 0", ins, we, rds, mem_read, e.wb_we);
            end
            pause(stall);
        end
        if (e.setf) m_flags = fl;
        m_pc = e.npc;
    endtask

    function automatic logic [15:0] rand_instr();
        logic [3:0] code;
        case ($urandom_range(0, 6))
            0: code = 4'b0101; 1: code = 4'b1001; 2: code = 4'b0001; 3: code = 4'b0010;
            4: code = 4'b0011; 5: code = 4'b1011; default: code = 4'b1101;
        endcase
        case ($urandom_range(0, 5))
            0: return {4'h0, 4'($urandom), code, 4'($urandom)};
            1: return {code, 4'($urandom), 8'($urandom)};
            2: return {4'hF, 4'($urandom), 8'($urandom)};
            3: return {4'h4, 4'($urandom), 4'h0, 4'($urandom)};
            4: return {4'h4, 4'($urandom), 4'h4, 4'($urandom)};
            default: return {4'hC, 4'($urandom), 8'($urandom)};
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; instr = 16'hFFFF; sflags = 5'h1F;
        step(); step();
        tests++;
        if (pc !== 16'h0000 || we !== 16'h0 || mem_read !== 1'b0 || mem_write !== 1'b0 || halted !== 1'b0 ||
            opc !== 4'h0 || imm !== 16'h0 || a_sel !== 4'h0 || b_sel !== 4'h0 || rds !== 1'b0) begin
            failed++;
            $display("FAIL reset: pc=%h we=%h rd=%b wr=%b halted=%b op=%b imm=%h, expected all zero", pc, we, mem_read, mem_write, halted, opc, imm);
        end
        rst = 1'b0; #1;
        m_pc = 16'h0000; m_flags = 5'b0;
    endtask

    task automatic test_movi_addi();
        do_reset();
        exec(16'hD105, 5'($urandom), 1'b0);
        exec(16'h51FF, 5'($urandom), 1'b0);
        tests++;
        if (pc !== 16'h0002) begin failed++; $display("FAIL movi_addi_pc: pc=%h, expected 0002", pc); end
    endtask

    task automatic test_cmp_beq();
        do_reset();
        exec(16'h02D3, 5'b0, 1'b0);
        exec(16'h03D4, 5'b0, 1'b0);
        exec(16'h04D5, 5'b0, 1'b0);
        exec(16'h01B2, 5'b01000, 1'b0);
        exec(16'hC003, 5'b00000, 1'b0);
        tests++;
        if (pc !== 16'h0007) begin failed++; $display("FAIL beq_pc: pc=%h, expected 0007", pc); end
    endtask

    task automatic test_bne_wrap();
        do_reset();
        exec(16'hC1FE, 5'b01000, 1'b0);
        tests++;
        if (pc !== 16'hFFFE) begin failed++; $display("FAIL bne_wrap: pc=%h, expected fffe", pc); end
        exec(16'h02D3, 5'b0, 1'b0);
        exec(16'h02D3, 5'b0, 1'b0);
        tests++;
        if (pc !== 16'h0000) begin failed++; $display("FAIL pc_wrap: pc=%h, expected 0000", pc); end
    endtask

    task automatic test_load();
        do_reset();
        exec(16'h4304, 5'b0, 1'b0);
        tests++;
        if (pc !== 16'h0001) begin failed++; $display("FAIL load_pc: pc=%h, expected 0001", pc); end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        step(); instr = 16'h4304;
        step(); instr = 16'h02D3;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; #1;
        tests++;
        if (pc !== 16'h0000 || we !== 16'h0 || mem_read !== 1'b1 || rds !== 1'b0) begin
            failed++;
            $display("FAIL reset_mid_load: pc=%h we=%h rd=%b rds=%b, expected 0000 0000 1 0", pc, we, mem_read, rds);
        end
        m_pc = 16'h0000; m_flags = 5'b0;
        exec(16'h02D3, 5'b0, 1'b0);
    endtask

    task automatic test_halt();
        do_reset();
        exec(16'h02D3, 5'b0, 1'b0);
        exec(16'h0000, 5'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            tests++;
            if (halted !== 1'b1 || pc !== 16'h0001 || mem_read !== 1'b0 || mem_write !== 1'b0 || we !== 16'h0) begin
                failed++;
                $display("FAIL halt_hold %0d: halted=%b pc=%h rd=%b wr=%b we=%h, expected 1 0001 0 0 0000", i, halted, pc, mem_read, mem_write, we);
            end
        end
    endtask

    task automatic test_illegal();
        do_reset();
        exec(16'h7000, 5'b0, 1'b0);
        tests++;
        if (halted !== TRAP || pc !== (TRAP ? 16'h0000 : 16'h0001)) begin
            failed++;
            $display("FAIL illegal_op: halted=%b pc=%h, expected %b %h", halted, pc, TRAP, TRAP ? 16'h0000 : 16'h0001);
        end
        if (!TRAP) begin
            exec(16'h0170, 5'b0, 1'b0);
            tests++;
            if (pc !== 16'h0002) begin failed++; $display("FAIL illegal_ext: pc=%h, expected 0002", pc); end
        end
    endtask

    task automatic test_random(input int n, input bit stall);
        do_reset();
        for (int i = 0; i < n; i++) exec(rand_instr(), 5'($urandom), stall);
    endtask

    initial begin
        test_reset();
        test_movi_addi();
        test_cmp_beq();
        test_bne_wrap();
        test_load();
        test_reset_mid_load();
        test_halt();
        test_illegal();
        test_random(300, 1'b0);
        test_random(300, 1'b1);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
